// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Update channel into the display controller: valid/ready plus the new frame contents.
interface seg7_scan_controller_if import seg7_pkg::*; ();

    logic                      upd_valid;
    logic                      upd_ready;
    logic [4*NUM_DIGITS-1:0]   upd_digits;
    logic [NUM_DIGITS-1:0]     upd_enable;
    logic [NUM_DIGITS-1:0]     upd_dp;
    logic                      upd_lzb;

    modport master (
        output upd_valid, upd_digits, upd_enable, upd_dp, upd_lzb,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_digits, upd_enable, upd_dp, upd_lzb,
        output upd_ready
    );

endinterface

// File: rtl/seg7_scan_controller_bcd_seg_decoder.sv
// BCD nibble to active-low 7-segment pattern; codes 10..15 display "E".
module bcd_seg_decoder import seg7_pkg::*; (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Eight-digit multiplexed 7-segment scanner with frame-aligned double-buffered updates.
//   state | meaning
//   BLANK | all anodes off for BLANK_CYCLES before the current digit (ghost suppression)
//   SHOW  | current digit lit for DWELL_CYCLES, then advance index (wrap 7->0 = frame boundary)
module seg7_scan_controller import seg7_pkg::*; #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    seg7_scan_controller_if.slave      upd,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic                       frame_tick
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] act_digits, shd_digits;
    logic [NUM_DIGITS-1:0]   act_enable, shd_enable;
    logic [NUM_DIGITS-1:0]   act_dp, shd_dp;
    logic                    act_lzb, shd_lzb;
    logic                    pending;
    logic                    ready_q;

    logic [NUM_DIGITS-1:0]   lit_mask;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic                    xfer;
    logic                    apply;

    assign upd.upd_ready = ready_q;
    assign xfer          = upd.upd_valid && ready_q;
    assign apply         = wrap && pending;

    // A digit is suppressed by lzb when it and every more-significant nibble are zero.
    always_comb begin : lzb_calc
        logic all_zero;
        lit_mask = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (act_digits[4*i +: 4] == 4'd0);
            lit_mask[i] = act_enable[i] && !(act_lzb && all_zero && (i != 0));
        end
    end

    // idx only changes on entry to BLANK, so the current index is also the next SHOW digit.
    bcd_seg_decoder u_dec (
        .bcd (act_digits[{idx, 2'b00} +: 4]),
        .seg (seg_dec)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        an_nxt    = '1;
        seg_nxt   = SEG_BLANK;
        dp_nxt    = 1'b1;

        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 1'b1;
                    wrap      = (idx == IDX_LAST);
                end
            end
        endcase

        // Segments stay dark whenever no anode is driven, so a disabled slot is fully off.
        if (state_nxt == SHOW && lit_mask[idx]) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = seg_dec;
            dp_nxt      = ~act_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
            act_digits <= '0;
            act_enable <= '0;
            act_dp     <= '0;
            act_lzb    <= 1'b0;
            shd_digits <= '0;
            shd_enable <= '0;
            shd_dp     <= '0;
            shd_lzb    <= 1'b0;
            pending    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= wrap;
            if (apply) begin
                act_digits <= shd_digits;
                act_enable <= shd_enable;
                act_dp     <= shd_dp;
                act_lzb    <= shd_lzb;
                pending    <= 1'b0;
                ready_q    <= 1'b1;
            end else if (xfer) begin
                shd_digits <= upd.upd_digits;
                shd_enable <= upd.upd_enable;
                shd_dp     <= upd.upd_dp;
                shd_lzb    <= upd.upd_lzb;
                pending    <= 1'b1;
                ready_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed + randomized check of seg7_scan_controller against a time-slot reference model.
module tb_seg7_scan_controller;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    seg7_scan_controller_if upd();

    seg7_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is a fixed timeline of 8 slots, each BL dark cycles then DW lit.
    logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
                                 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};

    int          t = 0;
    logic        m_pend = 1'b0;
    logic [31:0] a_dig = '0, s_dig = '0;
    logic [7:0]  a_en = '0, s_en = '0, a_dp = '0, s_dp = '0;
    logic        a_lzb = 1'b0, s_lzb = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check();
        int         pos, slot;
        logic       show, lit;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        pos  = t % FRAME;
        slot = pos / SLOT;
        show = (pos % SLOT) >= BL;
        lit  = show && a_en[slot] && !(a_lzb && slot >= 1 && (a_dig >> (4*slot)) == 32'd0);
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        if (lit) begin
            exp_an[slot] = 1'b0;
            exp_seg      = dec_tab[(a_dig >> (4*slot)) & 32'hF];
            exp_dp       = ~a_dp[slot];
        end
        cmp("an", an, exp_an);
        cmp("seg", {1'b0, seg}, {1'b0, exp_seg});
        cmp("dp", {7'd0, dp}, {7'd0, exp_dp});
        cmp("frame_tick", {7'd0, frame_tick}, {7'd0, (t > 0 && pos == 0)});
        cmp("upd_ready", {7'd0, upd.upd_ready}, {7'd0, !m_pend});
    endtask

    task automatic step();
        logic xfer;
        @(posedge clk);
        if (reset) begin
            t = 0; m_pend = 1'b0;
            a_dig = '0; a_en = '0; a_dp = '0; a_lzb = 1'b0;
            s_dig = '0; s_en = '0; s_dp = '0; s_lzb = 1'b0;
        end else begin
            xfer = upd.upd_valid && !m_pend;
            t++;
            if (t % FRAME == 0 && m_pend) begin
                a_dig = s_dig; a_en = s_en; a_dp = s_dp; a_lzb = s_lzb;
                m_pend = 1'b0;
            end
            if (xfer) begin
                s_dig = upd.upd_digits; s_en = upd.upd_enable;
                s_dp = upd.upd_dp; s_lzb = upd.upd_lzb;
                m_pend = 1'b1;
            end
        end
        #1;
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < FRAME && (t % FRAME) != p; i++) step();
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dm, input logic lz);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        upd.upd_valid = 1'b1; upd.upd_digits = d; upd.upd_enable = en;
        upd.upd_dp = dm; upd.upd_lzb = lz;
        while (!acc && n < 3*FRAME) begin
            acc = upd.upd_ready;
            step();
            n++;
        end
        upd.upd_valid = 1'b0;
        if (!acc) begin
            miscompares++;
            $error("FAIL send_timeout t=%0d got=not_accepted exp=accepted", t);
        end
    endtask

    initial begin
        upd.upd_valid = 1'b0; upd.upd_digits = '0; upd.upd_enable = '0;
        upd.upd_dp = '0; upd.upd_lzb = 1'b0;

        // Reset and idle: dark display, ticks every frame after the first wrap.
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(100);

        // Plain digits, all enabled.
        send(32'h87654321, 8'hFF, 8'h00, 1'b0);
        run(2*FRAME);

        // Leading-zero blanking with an invalid nibble in digit 3.
        send(32'h0000A005, 8'hFF, 8'h00, 1'b1);
        run(FRAME + 10);

        // Back-to-back update: second waits for the first to be applied.
        send(32'h11223344, 8'hFF, 8'hF0, 1'b0);
        send(32'h99000000, 8'hFF, 8'h0F, 1'b1);
        run(2*FRAME + 5);

        // Reset in the middle of digit 3's SHOW with an update pending.
        run_to_pos(1);
        send(32'h55555555, 8'hFF, 8'hFF, 1'b0);
        run_to_pos(3*SLOT + BL + 1);
        upd.upd_valid = 1'b1;
        reset = 1'b1;
        step();
        upd.upd_valid = 1'b0;
        reset = 1'b0;
        run(2*FRAME);

        // Sparse enable and dp masks.
        send(32'h00000987, 8'b0000_0101, 8'b0000_0100, 1'b0);
        run(2*FRAME + 3);

        // Randomized traffic, including valid held while not ready with changing data.
        for (int i = 0; i < 700; i++) begin
            upd.upd_valid  = ($urandom_range(0, 3) == 0);
            upd.upd_digits = $urandom >> (4 * $urandom_range(0, 7));
            upd.upd_enable = $urandom;
            upd.upd_dp     = $urandom;
            upd.upd_lzb    = $urandom_range(0, 1);
            step();
        end
        upd.upd_valid = 1'b0;
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes eight active-low 7-segment digits on the board display from one shared anode/segment bus.
- Holds a double-buffered 8-digit BCD value and walks the digits with a dwell period and a ghost-suppression blanking gap.
- Decodes the selected digit and drives an/seg.
- Sits between the lab datapath (counters, calculators) and the top-level display pins. Updates are accepted through a valid/ready handshake and applied only at frame boundaries, so the display never tears.

Parameters:
- DWELL_CYCLES, 100000, clock cycles each digit's anode is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, 1000, clock cycles all anodes are off before each digit; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- upd_valid  input  1  new display contents offered
- upd_ready  output  1  block can accept an update
- upd_digits  input  32  eight BCD nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7
- upd_enable  input  8  per-digit enable mask, bit i = digit i
- upd_dp  input  8  per-digit decimal point, 1 = lit
- upd_lzb  input  1  leading-zero blanking enable
- an  output  8  anode enables, active-low, bit i = digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse when digit 0 begins a new frame

Behaviour:
- Reset (synchronous, active-high):
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, upd_ready=1.
  - Active and shadow registers cleared to 0 (digits, enable, dp, lzb), so the display is dark after reset.
  - State=BLANK, digit index=0, counter=0, no pending update.
- Reset asserted mid-frame or mid-handshake discards any pending update and returns to exactly the reset state on the next edge.
- FSM has two states:
  - BLANK: counter runs 0..BLANK_CYCLES-1 with an=8'hFF, seg=7'h7F, dp=1. On the last count, go to SHOW and clear the counter.
  - SHOW: counter runs 0..DWELL_CYCLES-1 with the anode for the current index driven. On the last count, go to BLANK, clear the counter, and set index = index+1 mod 8.
- Frame length is 8*(BLANK_CYCLES+DWELL_CYCLES) cycles. Disabled digits still take their time slot; the anode simply stays high.
- Outputs are registered. an/seg/dp change on the same clock edge as the state they belong to; there is no extra pipeline cycle.
- SHOW output for digit i:
  - an[i]=0 if enable[i] is set and digit i is not leading-zero blanked; all other an bits are 1.
  - seg = decode(nibble i); dp = ~dp_mask[i].
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 show "E" = 0000110.
- Leading-zero blanking: when lzb=1, digit i (i>=1) is blanked if it and every higher nibble are 0. Digit 0 is never blanked by lzb. The calculation uses the active digits value.
- Handshake:
  - A transfer occurs when upd_valid && upd_ready on a clock edge; the inputs are captured into the shadow registers and pending is set.
  - upd_ready = ~pending, registered.
  - Pending is applied at the frame boundary, i.e. the edge where index wraps 7→0 entering BLANK. On that edge, shadow is copied to active, pending clears, and upd_ready returns to 1 on the same edge.
- frame_tick pulses for the one cycle following that wrap edge. It pulses whether or not an update was applied. The first frame after reset does not pulse.
- Simultaneous events: a new transfer cannot occur on the apply edge because ready is 0 there. A transfer on the edge immediately after apply is legal and waits for the next frame.
- Holding upd_valid high while ready is low has no effect; no data is lost or overwritten.

Decomposition:
- Package seg7_pkg holds:
  - the segment pattern constants SEG_0..SEG_9, SEG_E, SEG_BLANK;
  - the FSM state encoding (BLANK, SHOW);
  - the constant NUM_DIGITS = 8.
- One sub-module, bcd_seg_decoder: purely combinational, 4-bit BCD in, 7-bit active-low segments out, invalid codes map to "E". It is instantiated once in the controller on the selected nibble.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, frame = 48 cycles):
- Reset, then no update for 100 cycles → an=FF, seg=7F, dp=1 throughout; upd_ready=1; frame_tick pulses every 48 cycles after the first wrap.
- Send digits=32'h87654321, enable=FF, dp=00, lzb=0 → upd_ready=0 until the next wrap. In the following frame, the digit-0 slot shows an=FE for 4 cycles with seg=1111001, preceded by 2 cycles of an=FF; digit 7 shows an=7F with seg=0000000.
- Send digits=32'h0000A005, lzb=1, enable=FF → digit 0 shows "5" (0010010); digit 3 shows "E" (0000110); digits 1 and 2 are lit with "0" (1000000); digits 4..7 keep an=FF.
- Send a second update one cycle after the first is accepted, holding valid → it is not accepted until the first is applied. It is then captured and applied exactly one frame later; the first value is displayed for one full frame.
- Assert reset in the middle of digit 3's SHOW with an update pending → the next cycle shows an=FF, seg=7F, upd_ready=1. The pending value is never displayed, and index restarts at 0.
- Send enable=8'b0000_0101, dp=8'b0000_0100 → only an=FE and an=FB ever go low, dp=0 only during digit 2's SHOW, and slot timing is unchanged (48-cycle frame).
